// File: rtl/alu_if.sv
// alu_if: operand/result bundle between the execute stage and the ALU.
// Optional macro ALU_FLAGS_EN adds the Overflow and Negative flags.
//
// Handshake: there is none. The master drives A, B and ALU_Code every
// cycle; the slave captures them on every rising clock edge and presents
// the registered result one cycle later. There is no valid, ready or stall.
interface alu_if;
  logic [15:0] A;
  logic [15:0] B;
  logic [2:0]  ALU_Code;
  logic [15:0] ALU_Out;
  logic        Carry;
  logic        isZero;
`ifdef ALU_FLAGS_EN
  logic        Overflow;
  logic        Negative;

  modport master (
    output A, B, ALU_Code,
    input  ALU_Out, Carry, isZero, Overflow, Negative
  );

  modport slave (
    input  A, B, ALU_Code,
    output ALU_Out, Carry, isZero, Overflow, Negative
  );
`else
  modport master (
    output A, B, ALU_Code,
    input  ALU_Out, Carry, isZero
  );

  modport slave (
    input  A, B, ALU_Code,
    output ALU_Out, Carry, isZero
  );
`endif
endinterface

// File: rtl/alu.sv
// alu: 16-bit registered arithmetic/logic unit.
// Combinational result from A, B, ALU_Code followed by one output register.
// Optional macro ALU_FLAGS_EN adds registered Overflow and Negative flags.
module alu (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  logic [15:0] res;
  logic        carry;
  logic [16:0] wide;
  logic [3:0]  amt;

  assign amt = bus.B[3:0];

  // Result and carry: the 17-bit "wide" value holds the extra bit that
  // becomes the carry, borrow or last shifted-out bit.
  always_comb begin
    wide  = 17'h0;
    res   = 16'h0;
    carry = 1'b0;
    case (bus.ALU_Code)
      OP_ADD: begin
        wide  = {1'b0, bus.A} + {1'b0, bus.B};
        res   = wide[15:0];
        carry = wide[16];
      end
      OP_SUB: begin
        // Bit 16 of the 17-bit difference is set exactly when A < B.
        wide  = {1'b0, bus.A} - {1'b0, bus.B};
        res   = wide[15:0];
        carry = wide[16];
      end
      OP_AND: res = bus.A & bus.B;
      OP_OR:  res = bus.A | bus.B;
      OP_XOR: res = bus.A ^ bus.B;
      OP_NOT: res = ~bus.A;
      OP_SLL: begin
        // Bit 16 catches A[16-amt]; stays 0 for a zero shift.
        wide  = {1'b0, bus.A} << amt;
        res   = wide[15:0];
        carry = wide[16];
      end
      OP_SRL: begin
        // Bit 0 catches A[amt-1]; stays 0 for a zero shift.
        wide  = {bus.A, 1'b0} >> amt;
        res   = wide[16:1];
        carry = wide[0];
      end
      default: begin
        wide  = 17'h0;
        res   = 16'h0;
        carry = 1'b0;
      end
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic ovf;

  // Signed overflow: only ADD and SUB can overflow.
  always_comb begin
    ovf = 1'b0;
    case (bus.ALU_Code)
      OP_ADD:  ovf = (bus.A[15] == bus.B[15]) && (res[15] != bus.A[15]);
      OP_SUB:  ovf = (bus.A[15] != bus.B[15]) && (res[15] != bus.A[15]);
      default: ovf = 1'b0;
    endcase
  end

  // Extra flag registers, cleared to 0 by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.Overflow <= 1'b0;
      bus.Negative <= 1'b0;
    end else begin
      bus.Overflow <= ovf;
      bus.Negative <= res[15];
    end
  end
`endif

  // Output register; reset shows a zero result, so isZero resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ALU_Out <= 16'h0000;
      bus.Carry   <= 1'b0;
      bus.isZero  <= 1'b1;
    end else begin
      bus.ALU_Out <= res;
      bus.Carry   <= carry;
      bus.isZero  <= (res == 16'h0000);
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb_alu: randomized and directed bench for alu against a behavioural model.
// Expected vector layout: {Overflow, Negative, isZero, Carry, ALU_Out}.
module tb_alu;

  logic clk;
  logic rst_n;

  alu_if bus ();

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_checks;
  int unsigned n_fails;

  logic [19:0] exp_q[$];

  localparam logic [19:0] RESET_VEC = 20'h20000;

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT outputs packed like the model output.
  function automatic logic [19:0] actual_vec();
    logic ov;
    logic ng;
`ifdef ALU_FLAGS_EN
    ov = bus.Overflow;
    ng = bus.Negative;
`else
    ov = 1'b0;
    ng = 1'b0;
`endif
    return {ov, ng, bus.isZero, bus.Carry, bus.ALU_Out};
  endfunction

  // Behavioural model using plain integer arithmetic.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic [2:0] code);
    int unsigned ai;
    int unsigned bi;
    int unsigned amt;
    int unsigned r;
    int          sa;
    int          sb;
    int          sr;
    bit          c;
    bit          ov;
    bit          ng;
    bit          z;
    logic [15:0] r16;
    ai  = a;
    bi  = b;
    amt = bi % 16;
    sa  = (ai >= 32768) ? int'(ai) - 65536 : int'(ai);
    sb  = (bi >= 32768) ? int'(bi) - 65536 : int'(bi);
    c   = 0;
    ov  = 0;
    r   = 0;
    case (code)
      3'd0: begin
        r  = ai + bi;
        c  = (r > 65535);
        r  = r % 65536;
        sr = sa + sb;
        ov = (sr > 32767) || (sr < -32768);
      end
      3'd1: begin
        c  = (ai < bi);
        r  = (ai + 65536 - bi) % 65536;
        sr = sa - sb;
        ov = (sr > 32767) || (sr < -32768);
      end
      3'd2: r = ai & bi;
      3'd3: r = ai | bi;
      3'd4: r = ai ^ bi;
      3'd5: r = 65535 - ai;
      3'd6: begin
        r = ai * (32'd1 << amt);
        c = (amt != 0) && (((r / 65536) % 2) == 1);
        r = r % 65536;
      end
      default: begin
        r = ai / (32'd1 << amt);
        c = (amt != 0) && (((ai / (32'd1 << (amt - 1))) % 2) == 1);
      end
    endcase
    r16 = r[15:0];
    z   = (r == 0);
    ng  = (r >= 32768);
`ifndef ALU_FLAGS_EN
    ov = 0;
    ng = 0;
`endif
    return {ov, ng, z, c, r16};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: 1 unit after each rising edge, check reset values
  // while in reset, otherwise the oldest expected result.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      check("reset_hold", actual_vec(), RESET_VEC);
    end else if (exp_q.size() > 0) begin
      check("model", actual_vec(), exp_q.pop_front());
    end
  end

  // Driver: called at rising edge + 2; applies inputs and waits until the
  // result has been captured (next rising edge + 2).
  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] code);
    bus.A        = a;
    bus.B        = b;
    bus.ALU_Code = code;
    exp_q.push_back(model(a, b, code));
    @(posedge clk);
    #2;
  endtask

  task automatic lit_out(input string name, input logic [15:0] val);
    check(name, {4'h0, bus.ALU_Out}, {4'h0, val});
  endtask

  task automatic lit_bit(input string name, input logic act, input logic val);
    check(name, {19'h0, act}, {19'h0, val});
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n        = 1'b0;
    bus.A        = 16'h1234;
    bus.B        = 16'hABCD;
    bus.ALU_Code = 3'd0;

    // Reset with arbitrary inputs toggling.
    repeat (3) begin
      @(posedge clk);
      #2;
      bus.A        = 16'($urandom);
      bus.B        = 16'($urandom);
      bus.ALU_Code = 3'($urandom);
    end
    rst_n = 1'b1;

    // Directed cases with hand-computed values.
    drive(16'd5, 16'd2, 3'b011);
    lit_out("or_after_reset", 16'd7);

    drive(16'hFFFF, 16'h0001, 3'b000);
    lit_out("add_wrap_out", 16'h0000);
    lit_bit("add_wrap_c", bus.Carry, 1'b1);
    lit_bit("add_wrap_z", bus.isZero, 1'b1);
    drive(16'd5, 16'd2, 3'b000);
    lit_out("add_out", 16'd7);
    lit_bit("add_c", bus.Carry, 1'b0);

    drive(16'd2, 16'd5, 3'b001);
    lit_out("sub_borrow_out", 16'hFFFD);
    lit_bit("sub_borrow_c", bus.Carry, 1'b1);
    drive(16'd5, 16'd5, 3'b001);
    lit_out("sub_zero_out", 16'h0000);
    lit_bit("sub_zero_z", bus.isZero, 1'b1);
    lit_bit("sub_zero_c", bus.Carry, 1'b0);

    drive(16'h0F0F, 16'h00FF, 3'b010);
    lit_out("and_out", 16'h000F);
    lit_bit("and_c", bus.Carry, 1'b0);
    drive(16'h0F0F, 16'h00FF, 3'b100);
    lit_out("xor_out", 16'h0FF0);
    drive(16'h0F0F, 16'h00FF, 3'b101);
    lit_out("not_out", 16'hF0F0);
    lit_bit("not_c", bus.Carry, 1'b0);

    drive(16'h8001, 16'd1, 3'b110);
    lit_out("sll_out", 16'h0002);
    lit_bit("sll_c", bus.Carry, 1'b1);
    drive(16'h8001, 16'd1, 3'b111);
    lit_out("srl_out", 16'h4000);
    lit_bit("srl_c", bus.Carry, 1'b1);
    drive(16'h8001, 16'h0010, 3'b110);
    lit_out("sll_zero_amt", 16'h8001);
    lit_bit("sll_zero_amt_c", bus.Carry, 1'b0);
    drive(16'h8001, 16'h0010, 3'b111);
    lit_out("srl_zero_amt", 16'h8001);
    lit_bit("srl_zero_amt_c", bus.Carry, 1'b0);

`ifdef ALU_FLAGS_EN
    drive(16'h7FFF, 16'd1, 3'b000);
    lit_out("add_ovf_out", 16'h8000);
    lit_bit("add_ovf", bus.Overflow, 1'b1);
    lit_bit("add_neg", bus.Negative, 1'b1);
    drive(16'h8000, 16'd1, 3'b001);
    lit_bit("sub_ovf", bus.Overflow, 1'b1);
`endif

    // Randomized stream.
    for (int i = 0; i < 400; i++) begin
      drive(pick(), pick(), 3'($urandom));
    end

    // Mid-stream reset: the in-flight operation is discarded.
    bus.A        = 16'h1111;
    bus.B        = 16'h2222;
    bus.ALU_Code = 3'b000;
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", actual_vec(), RESET_VEC);
    exp_q.delete();
    @(posedge clk);
    #2;
    check("reset_still", actual_vec(), RESET_VEC);
    rst_n = 1'b1;
    #1;
    check("reset_release_hold", actual_vec(), RESET_VEC);
    #1;

    for (int i = 0; i < 200; i++) begin
      drive(16'($urandom), 16'($urandom), 3'($urandom));
    end

    // Let the compare process drain anything left.
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

16-bit registered arithmetic/logic unit for the 16-bit CPU datapath. It sits between the register-file read ports and the write-back mux. The execute stage drives two operands and a 3-bit operation code each cycle. The unit returns a 16-bit result plus carry and zero flags, registered one clock later.

## Interface
Parameters:
- none; the data width is fixed at 16 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  16  operand A (unsigned / two's complement).
- B  input  16  operand B; shift amount for the shift ops is B[3:0].
- ALU_Code  input  3  operation select.
- ALU_Out  output  16  registered result.
- Carry  output  1  registered carry/borrow/shift-out flag.
- isZero  output  1  registered flag; 1 when ALU_Out == 16'h0000.
- Overflow  output  1  signed overflow flag; present only with ALU_FLAGS_EN.
- Negative  output  1  equals ALU_Out[15]; present only with ALU_FLAGS_EN.

## Operation
ALU_Code map (R is the 16-bit result, C is the carry):
- 000 ADD: {C,R} = A + B, computed as a 17-bit sum.
- 001 SUB: R = A - B modulo 2^16. C = 1 on borrow (A < B unsigned), else 0.
- 010 AND: R = A & B; C = 0.
- 011 OR: R = A | B; C = 0.
- 100 XOR: R = A ^ B; C = 0.
- 101 NOT: R = ~A; B is ignored; C = 0.
- 110 SLL: R = A << B[3:0], zero fill. C = last bit shifted out, i.e. A[16-B[3:0]]. C = 0 when the amount is 0.
- 111 SRL: R = A >> B[3:0], zero fill. C = last bit shifted out, i.e. A[B[3:0]-1]. C = 0 when the amount is 0.

Flag and input rules:
- B[15:4] are ignored for shifts.
- isZero is derived from the computed R, so it is always consistent with ALU_Out in the same cycle.
- The result logic is purely combinational from A, B and ALU_Code, followed by one output register stage. There is no internal state other than the output registers.
- No X-propagation is tolerated: every code, including ones not exercised by a test, produces a defined result.

## Timing
- Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on the outputs after edge N and hold until edge N+1.
- Throughput: one operation per cycle. No handshake and no stall; outputs update every edge.
- Reset: when rst_n falls, the outputs go immediately (asynchronously) to ALU_Out = 0, Carry = 0, isZero = 1, Overflow = 0, Negative = 0.
- Reset is released synchronously with respect to the design: the first capture happens at the first rising edge with rst_n high.
- Reset mid-stream: any in-flight result is discarded. The post-reset values above hold until the first capture.
- Input changes between edges have no effect on the outputs.

## Configuration
- Macro ALU_FLAGS_EN.
- When defined:
  - Ports Overflow and Negative exist and are registered alongside the other outputs.
  - Overflow for ADD = (A[15] == B[15]) && (R[15] != A[15]).
  - Overflow for SUB = (A[15] != B[15]) && (R[15] != A[15]).
  - Overflow is 0 for all other codes.
  - Negative = R[15].
- When undefined: both ports and their registers are absent, and all other behaviour is identical.

## Test plan
- Reset: hold rst_n = 0 with arbitrary inputs -> ALU_Out = 0, Carry = 0, isZero = 1. Release, then apply A = 5, B = 2, code 011 -> after one edge ALU_Out = 7.
- ADD wrap: A = 16'hFFFF, B = 16'h0001, code 000 -> ALU_Out = 0, Carry = 1, isZero = 1. Then A = 5, B = 2 -> ALU_Out = 7, Carry = 0.
- SUB borrow: A = 2, B = 5, code 001 -> ALU_Out = 16'hFFFD, Carry = 1. Then A = 5, B = 5 -> ALU_Out = 0, isZero = 1, Carry = 0.
- Logic ops with A = 16'h0F0F, B = 16'h00FF:
  - code 010 -> 16'h000F.
  - code 100 -> 16'h0FF0.
  - code 101 -> 16'hF0F0.
  - Carry = 0 for all three.
- Shifts:
  - A = 16'h8001, B = 1, code 110 -> ALU_Out = 16'h0002, Carry = 1.
  - A = 16'h8001, B = 1, code 111 -> ALU_Out = 16'h4000, Carry = 1.
  - B = 16'h0010 (amount 0) -> ALU_Out = A, Carry = 0.
- ALU_FLAGS_EN:
  - A = 16'h7FFF, B = 1, code 000 -> ALU_Out = 16'h8000, Overflow = 1, Negative = 1.
  - A = 16'h8000, B = 1, code 001 -> Overflow = 1.
  - Each result changes exactly one cycle after the input changes.
